// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and bundle types for the RGB LCD raster driver.
// Two panel presets plus coordinate/pixel widths.
package lcd_timing_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 24;
  localparam int MAX_TOTAL = 2048;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned valid;
    int unsigned front;
  } lcd_axis_t;

  localparam lcd_axis_t LCD_800x480_H = '{sync: 128, back: 88, valid: 800, front: 40};
  localparam lcd_axis_t LCD_800x480_V = '{sync: 2, back: 33, valid: 480, front: 10};
  localparam lcd_axis_t LCD_480x272_H = '{sync: 41, back: 2, valid: 480, front: 2};
  localparam lcd_axis_t LCD_480x272_V = '{sync: 10, back: 2, valid: 272, front: 2};

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic int unsigned axis_total(lcd_axis_t a);
    return a.sync + a.back + a.valid + a.front;
  endfunction

endpackage

// File: rtl/lcd_timing_driver_counter.sv
// Free-running horizontal/vertical raster counter pair.
// v advances on the h wrap; both wrap together at end of frame.
module lcd_sync_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL = 1056,
  parameter int V_TOTAL = 525
) (
  input  logic               clk_in,
  input  logic               sys_rst,
  output logic [COORD_W-1:0] h_cnt_o,
  output logic [COORD_W-1:0] v_cnt_o
);

  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic               h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == COORD_W'(H_TOTAL - 1));
    v_wrap = h_wrap && (v_q == COORD_W'(V_TOTAL - 1));
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (v_wrap) begin
      v_d = '0;
    end else if (h_wrap) begin
      v_d = v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;

endmodule

// File: rtl/lcd_timing_driver.sv
// Raster timing generator and panel output stage for an RGB LCD.
// Sync/DE are delayed to line up with the pixel source read latency.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC   = LCD_800x480_H.sync,
  parameter int H_BACK   = LCD_800x480_H.back,
  parameter int H_VALID  = LCD_800x480_H.valid,
  parameter int H_FRONT  = LCD_800x480_H.front,
  parameter int V_SYNC   = LCD_800x480_V.sync,
  parameter int V_BACK   = LCD_800x480_V.back,
  parameter int V_VALID  = LCD_800x480_V.valid,
  parameter int V_FRONT  = LCD_800x480_V.front,
  parameter int DATA_LAT = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk_in,
  input  logic               sys_rst,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_req,
  input  logic [RGB_W-1:0]   pix_data,
  output logic               frame_start,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_de,
  output logic [RGB_W-1:0]   lcd_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("lcd_timing_driver: H_TOTAL/V_TOTAL exceed 2048");
  end
  if (DATA_LAT < 1 || DATA_LAT > 4) begin : g_bad_lat
    $error("lcd_timing_driver: DATA_LAT must be 1..4");
  end

  logic [COORD_W-1:0] h_cnt, v_cnt;

  lcd_sync_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_cnt (
    .clk_in (clk_in),
    .sys_rst(sys_rst),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt)
  );

  // 12-bit compares so a region ending exactly at 2048 still decodes
  logic [COORD_W:0] h_ext, v_ext;
  sync_t            raw;
  logic [COORD_W-1:0] x_d, y_d;
  logic               fs_d;

  always_comb begin
    h_ext  = {1'b0, h_cnt};
    v_ext  = {1'b0, v_cnt};
    raw.hs = h_ext < 12'(H_SYNC);
    raw.vs = v_ext < 12'(V_SYNC);
    raw.de = (h_ext >= 12'(H_ACT)) && (h_ext < 12'(H_ACT + H_VALID))
          && (v_ext >= 12'(V_ACT)) && (v_ext < 12'(V_ACT + V_VALID));
    x_d    = raw.de ? h_cnt - COORD_W'(H_ACT) : '0;
    y_d    = raw.de ? v_cnt - COORD_W'(V_ACT) : '0;
    fs_d   = (h_cnt == '0) && (v_cnt == '0);
  end

  sync_t              req_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               fs_q;
  sync_t              pipe_q [DATA_LAT];
  sync_t              tail;
  logic               hs_q, vs_q, de_q;
  logic [RGB_W-1:0]   rgb_q;

  assign tail = pipe_q[DATA_LAT-1];

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      req_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      for (int i = 0; i < DATA_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      req_q     <= raw;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      pipe_q[0] <= req_q;
      for (int i = 1; i < DATA_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      hs_q  <= tail.hs ~^ HS_POL;
      vs_q  <= tail.vs ~^ VS_POL;
      de_q  <= tail.de;
      rgb_q <= tail.de ? pix_data : '0;
    end
  end

  assign pix_req     = req_q.de;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver: scoreboarded small-raster instance plus
// directed checks of the default 800x480 timing up to the first active line.
module tb_lcd_timing_driver;

  localparam int SH = 2, BH = 2, AH = 4, FH = 2;
  localparam int SV = 1, BV = 1, AV = 3, FV = 1;
  localparam int HT = SH + BH + AH + FH;
  localparam int VT = SV + BV + AV + FV;
  localparam int LS = 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } lo_t;

  typedef struct packed {
    logic        req;
    logic        fs;
    logic [10:0] x;
    logic [10:0] y;
  } rq_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // small raster, active-high syncs, DATA_LAT=3
  logic        rst_s;
  logic [10:0] px_s, py_s;
  logic        req_s, fs_s, hs_s, vs_s, de_s;
  logic [23:0] pd_s, rgb_s;

  lcd_timing_driver #(
    .H_SYNC(SH), .H_BACK(BH), .H_VALID(AH), .H_FRONT(FH),
    .V_SYNC(SV), .V_BACK(BV), .V_VALID(AV), .V_FRONT(FV),
    .DATA_LAT(LS), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk_in(clk), .sys_rst(rst_s),
    .pix_x(px_s), .pix_y(py_s), .pix_req(req_s), .pix_data(pd_s),
    .frame_start(fs_s), .lcd_hs(hs_s), .lcd_vs(vs_s), .lcd_de(de_s),
    .lcd_rgb(rgb_s)
  );

  logic [23:0] src_s [LS];
  always @(posedge clk) begin
    src_s[0] <= {5'b0, py_s, px_s[7:0]};
    for (int i = 1; i < LS; i++) src_s[i] <= src_s[i-1];
  end
  assign pd_s = src_s[LS-1];

  // default 800x480 instance, DATA_LAT=1
  logic        rst_d;
  logic [10:0] px_d, py_d;
  logic        req_d, fs_d, hs_d, vs_d, de_d;
  logic [23:0] pd_d, rgb_d;

  lcd_timing_driver dut_d (
    .clk_in(clk), .sys_rst(rst_d),
    .pix_x(px_d), .pix_y(py_d), .pix_req(req_d), .pix_data(pd_d),
    .frame_start(fs_d), .lcd_hs(hs_d), .lcd_vs(vs_d), .lcd_de(de_d),
    .lcd_rgb(rgb_d)
  );

  always @(posedge clk) pd_d <= {5'b0, py_d, px_d[7:0]};

  function automatic logic in_de(int h, int v);
    return h >= SH + BH && h < SH + BH + AH && v >= SV + BV && v < SV + BV + AV;
  endfunction

  function automatic lo_t exp_lo(int h, int v);
    lo_t o;
    logic [10:0] x, y;
    x = in_de(h, v) ? 11'(h - SH - BH) : 11'd0;
    y = in_de(h, v) ? 11'(v - SV - BV) : 11'd0;
    o.hs  = (h < SH);
    o.vs  = (v < SV);
    o.de  = in_de(h, v);
    o.rgb = o.de ? {5'b0, y, x[7:0]} : 24'h0;
    return o;
  endfunction

  function automatic rq_t exp_rq(int h, int v);
    rq_t r;
    r.req = in_de(h, v);
    r.fs  = (h == 0 && v == 0);
    r.x   = r.req ? 11'(h - SH - BH) : 11'd0;
    r.y   = r.req ? 11'(v - SV - BV) : 11'd0;
    return r;
  endfunction

  lo_t qo[$];
  rq_t qr[$];
  int  mh = 0, mv = 0;

  // stimulus-side model: push what the DUT must show later
  always @(posedge clk) begin
    if (rst_s) begin
      qo.delete();
      qr.delete();
      repeat (LS + 2) qo.push_back(lo_t'(0));
      qr.push_back(rq_t'(0));
      mh = 0;
      mv = 0;
    end else begin
      qo.push_back(exp_lo(mh, mv));
      qr.push_back(exp_rq(mh, mv));
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // monitor: pop and compare every cycle
  always @(negedge clk) begin
    lo_t eo, go;
    rq_t er, gr;
    go = '{hs: hs_s, vs: vs_s, de: de_s, rgb: rgb_s};
    gr = '{req: req_s, fs: fs_s, x: px_s, y: py_s};
    total++;
    if (qo.size() == 0) begin
      bad++;
      $display("FAIL lcd_queue_empty got=%h", go);
    end else begin
      eo = qo.pop_front();
      if (go !== eo) begin
        bad++;
        if (bad < 30) $display("FAIL lcd_out t=%0t got=%h exp=%h", $time, go, eo);
      end
    end
    total++;
    if (qr.size() == 0) begin
      bad++;
      $display("FAIL req_queue_empty got=%h", gr);
    end else begin
      er = qr.pop_front();
      if (gr !== er) begin
        bad++;
        if (bad < 30) $display("FAIL req_out t=%0t got=%h exp=%h", $time, gr, er);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic run_small();
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    repeat (3 * HT * VT + 23) @(negedge clk);
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    repeat (3 * HT * VT + 10) @(negedge clk);
  endtask

  task automatic run_default();
    int n, cnt, low;
    rst_d = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hs", int'(hs_d), 1);
    chk("rst_vs", int'(vs_d), 1);
    chk("rst_de", int'(de_d), 0);
    chk("rst_req", int'(req_d), 0);
    rst_d = 1'b0;
    n = 0;
    @(negedge clk);
    n++;
    chk("frame_start_first", int'(fs_d), 1);
    while (!req_d && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_clock", n, 37177);
    chk("first_req_x", int'(px_d), 0);
    chk("first_req_y", int'(py_d), 0);
    @(negedge clk);
    n++;
    chk("second_req_x", int'(px_d), 1);
    while (!de_d && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("de_rise_clock", n, 37179);
    chk("vs_inactive", int'(vs_d), 1);
    chk("first_rgb", int'(rgb_d), 0);
    cnt = 0;
    while (de_d && cnt < 2000) begin
      if (cnt == 1) chk("rgb_x1", int'(rgb_d), 1);
      if (cnt == 799) chk("rgb_x799", int'(rgb_d), 31);
      cnt++;
      @(negedge clk);
    end
    chk("de_run_len", cnt, 800);
    chk("rgb_blank", int'(rgb_d), 0);
    low = 0;
    repeat (1056) begin
      if (!hs_d) low++;
      @(negedge clk);
    end
    chk("hs_low_per_line", low, 128);
  endtask

  initial begin
    rst_s = 1'b1;
    rst_d = 1'b1;
    fork
      run_small();
      run_default();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
